// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall sequencer for a classic 5-stage MIPS pipeline.
//   Decodes load-use hazards, taken branches/jumps and multi-cycle data
//   memory waits into PC / IF-ID / ID-EX / back-end control strobes.
//   Also keeps a memory-wait timeout watchdog and saturating perf counters.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   ifid_rs_i/_rt_i       source register fields of the IF/ID instruction
//   ifid_uses_rt_i        IF/ID instruction reads rt
//   idex_rt_i             load destination of the ID/EX instruction
//   idex_memread_i        ID/EX instruction is a load
//   branch_taken_i/jump_i control-flow change resolved in ID
//   mem_busy_i            data memory not ready this cycle
//   pc_write_o            PC load enable
//   ifid_write_o          IF/ID load enable
//   ifid_flush_o          IF/ID loads a nop
//   idex_bubble_o         ID/EX loads zeroed control bits
//   pipe_freeze_o         ID/EX, EX/MEM, MEM/WB hold
//   state_o               0 = RUN, 1 = MEMWAIT
//   err_o                 sticky memory-wait timeout
//   stall_cnt_o           saturating count of cycles with pc_write_o = 0
//   flush_cnt_o           saturating count of cycles with ifid_flush_o = 1
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_e;

  localparam logic [7:0]       TO_LIM  = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             lu;

  // rt only matters when the consumer actually reads it; $zero never hazards
  assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q;
    if (rst_i) begin
      // hold the front end and inject bubbles while in reset
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (mem_busy_i) begin
      // memory wait dominates everything; IF/ID keeps presenting any
      // pending branch/jump so nothing is lost
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
      state_d       = MEMWAIT;
      if (state_q == RUN)         wcnt_d = 8'd1;
      else if (wcnt_q != 8'hFF)   wcnt_d = wcnt_q + 8'd1;
      if (wcnt_d >= TO_LIM)       err_d  = 1'b1;
    end else begin
      // RUN, or the exit cycle of MEMWAIT: same priority either way
      state_d = RUN;
      wcnt_d  = 8'd0;
      if (lu) begin
        // branch compare operand is stale here, so branch/jump waits
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i || jump_i) begin
        ifid_flush_o  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write_o && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    if (ifid_flush_o && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule
